// File: rtl/scan_seq.sv
// scan_seq: UART-commanded pan/tilt positioning followed by one ultrasonic
// range measurement. A frame 0x0F, x, y moves the servos, waits for them to
// settle, fires the trigger, times the echo in microseconds and returns the
// 16-bit result as two bytes (high byte first). A result of 0xFFFF means no
// echo arrived, or the echo was too long to be a valid range.
module scan_seq #(
    parameter int unsigned CLK_PER_US   = 50,
    parameter int unsigned SETTLE_US    = 200,
    parameter int unsigned TRIG_US      = 10,
    parameter int unsigned ECHO_WAIT_US = 30000,
    parameter int unsigned ECHO_MAX_US  = 38000
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] servo1_pos,
    output logic [7:0] servo2_pos,
    output logic       trig,
    input  logic       cap_sig,
    output logic       busy
);

    localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_US - 1);
    localparam logic [15:0] TRIG_END    = 16'(TRIG_US);
    localparam logic [15:0] WAIT_LAST   = 16'(ECHO_WAIT_US - 1);
    localparam logic [15:0] MAX_LAST    = 16'(ECHO_MAX_US - 1);
    localparam logic [15:0] NO_ECHO     = 16'hFFFF;
    localparam logic [7:0]  START_BYTE  = 8'h0F;

    typedef enum logic [3:0] {
        IDLE,
        GET_X,
        GET_Y,
        SETTLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        SEND_HI,
        SEND_LO
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [PRE_W-1:0]  pre_cnt;
    logic              us_tick;
    logic [15:0]       us_cnt;
    logic              state_chg;

    logic              cap_meta;
    logic              echo_s;

    logic [7:0]        x_reg;
    logic [15:0]       result;
    logic [15:0]       result_n;
    logic              load_x;
    logic              load_servo;
    logic              load_result;

    assign us_tick   = (pre_cnt == PRE_LAST);
    assign state_chg = (state_n != state);

    // Next-state decode and datapath load strobes.
    always_comb begin
        state_n     = state;
        load_x      = 1'b0;
        load_servo  = 1'b0;
        load_result = 1'b0;
        result_n    = result;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == START_BYTE) begin
                    state_n = GET_X;
                end
            end
            GET_X: begin
                if (rx_valid) begin
                    load_x  = 1'b1;
                    state_n = GET_Y;
                end
            end
            GET_Y: begin
                if (rx_valid) begin
                    load_servo = 1'b1;
                    state_n    = SETTLE;
                end
            end
            SETTLE: begin
                if (us_tick && us_cnt == SETTLE_LAST) begin
                    state_n = TRIG;
                end
            end
            TRIG: begin
                // The entry cycle is a lead-in with trig low, so the state
                // stays one cycle past the last tick to give a full-width pulse.
                if (us_cnt >= TRIG_END) begin
                    state_n = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                if (echo_s) begin
                    state_n = MEASURE;
                end else if (us_tick && us_cnt == WAIT_LAST) begin
                    load_result = 1'b1;
                    result_n    = NO_ECHO;
                    state_n     = SEND_HI;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    load_result = 1'b1;
                    result_n    = us_cnt;
                    state_n     = SEND_HI;
                end else if (us_tick && us_cnt == MAX_LAST) begin
                    load_result = 1'b1;
                    result_n    = NO_ECHO;
                    state_n     = SEND_HI;
                end
            end
            SEND_HI: begin
                if (tx_ready) begin
                    state_n = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Handshake and status outputs follow directly from the current state.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        busy     = (state != IDLE);
        case (state)
            SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = result[15:8];
            end
            SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = result[7:0];
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Microsecond timebase; both counters restart on every state entry.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else if (state_chg) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else begin
            pre_cnt <= us_tick ? '0 : pre_cnt + PRE_W'(1);
            if (us_tick && us_cnt != 16'hFFFF) begin
                us_cnt <= us_cnt + 16'd1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous echo input.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            cap_meta <= 1'b0;
            echo_s   <= 1'b0;
        end else begin
            cap_meta <= cap_sig;
            echo_s   <= cap_meta;
        end
    end

    // Position latches and measurement result.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            x_reg      <= '0;
            servo1_pos <= '0;
            servo2_pos <= '0;
            result     <= '0;
        end else begin
            if (load_x) begin
                x_reg <= rx_data;
            end
            if (load_servo) begin
                servo1_pos <= x_reg;
                servo2_pos <= rx_data;
            end
            if (load_result) begin
                result <= result_n;
            end
        end
    end

    // Trigger pulse: high on every TRIG cycle after the entry cycle.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            trig <= 1'b0;
        end else begin
            trig <= (state == TRIG) && (state_n == TRIG);
        end
    end

endmodule

// File: doc/scan_seq.md
SCAN_SEQ -- requirements
Module: scan_seq

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 50, meaning clk cycles per microsecond tick.
REQ-002 SHALL have parameter SETTLE_US, default 200, meaning servo settle wait in us before trigger.
REQ-003 SHALL have parameter TRIG_US, default 10, meaning trig pulse width in us.
REQ-004 SHALL have parameter ECHO_WAIT_US, default 30000, meaning maximum us from trig fall to echo rise.
REQ-005 SHALL have parameter ECHO_MAX_US, default 38000, meaning maximum measured echo width in us.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port rst_i  input  1  synchronous active-low reset.
REQ-008 SHALL have port rx_data  input  8  received UART byte.
REQ-009 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-011 SHALL have port tx_valid  output  1  tx_data valid; held until accepted.
REQ-012 SHALL have port tx_ready  input  1  transmitter can accept; transfer when tx_valid and tx_ready are both high.
REQ-013 SHALL have port servo1_pos  output  8  pan position to servo PWM generator.
REQ-014 SHALL have port servo2_pos  output  8  tilt position to servo PWM generator.
REQ-015 SHALL have port trig  output  1  ultrasonic trigger pulse.
REQ-016 SHALL have port cap_sig  input  1  asynchronous echo input from ranging sensor.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL synchronize cap_sig through two flops; all echo decisions use the synchronized value.
REQ-019 SHALL generate a 1-cycle us tick every CLK_PER_US cycles from a prescaler cleared on every state entry.
REQ-020 SHALL implement states IDLE, GET_X, GET_Y, SETTLE, TRIG, WAIT_ECHO, MEASURE, SEND_HI, SEND_LO.
REQ-021 IDLE: rx_valid with rx_data 0x0F -> GET_X; any other byte ignored, state unchanged.
REQ-022 GET_X: on rx_valid, latch rx_data into x register -> GET_Y.
REQ-023 GET_Y: on rx_valid, load servo1_pos <= x and servo2_pos <= rx_data in the same cycle -> SETTLE.
REQ-024 SETTLE: after SETTLE_US ticks -> TRIG.
REQ-025 TRIG: trig high for exactly TRIG_US*CLK_PER_US cycles, starting the cycle after entry, then low -> WAIT_ECHO.
REQ-026 WAIT_ECHO: synchronized echo high -> MEASURE with us counter 0; ECHO_WAIT_US ticks without rise -> result 0xFFFF -> SEND_HI.
REQ-027 MEASURE: count us ticks while echo high; on echo low, result = count -> SEND_HI; count reaching ECHO_MAX_US -> result 0xFFFF -> SEND_HI.
REQ-028 us counter SHALL be 16 bits and SHALL never wrap.
REQ-029 SEND_HI: tx_valid=1, tx_data=result[15:8]; on transfer -> SEND_LO.
REQ-030 SEND_LO: tx_valid=1, tx_data=result[7:0]; on transfer -> IDLE with tx_valid=0 the next cycle.
REQ-031 tx_data SHALL be stable while tx_valid is high and tx_ready is low.
REQ-032 rx_valid in SETTLE through SEND_LO SHALL be ignored with no buffering.
REQ-033 rx_valid in the same cycle as a state-exit condition SHALL be processed only if the current state consumes rx bytes.
REQ-034 trig SHALL be low in all states except TRIG.

Reset
REQ-035 SHALL, with rst_i low at a clk edge, go to IDLE and set servo1_pos=0x00, servo2_pos=0x00, trig=0, tx_valid=0, tx_data=0x00, busy=0, and clear all counters, the synchronizer and the result.
REQ-036 SHALL, on reset asserted in any state including mid-TRIG or mid-SEND, drop trig and tx_valid at that edge and send no partial frame afterward.

Verification
REQ-037 rx 0x0F,0x96,0x96; echo high 5800 us -> servo1_pos=servo2_pos=150, trig high exactly 500 cycles, tx bytes 0x16 then 0xA8, busy low after the second transfer.
REQ-038 frame 0x0F,0x10,0x20, cap_sig held low -> after ECHO_WAIT_US, tx 0xFF,0xFF; echo held high beyond ECHO_MAX_US -> tx 0xFF,0xFF.
REQ-039 rx 0x55, then 0x0F,0x01,0x02 -> 0x55 ignored; servo1_pos=1, servo2_pos=2.
REQ-040 tx_ready low for 100 cycles in SEND_HI -> tx_valid and tx_data=result[15:8] held steady throughout; exactly 2 bytes transferred.
REQ-041 rx bytes during SETTLE/MEASURE -> no effect on servo outputs or result.
REQ-042 rst_i low for 1 cycle mid-TRIG -> trig=0 on that edge, busy=0, no tx_valid until a new frame.
